// File: rtl/regfile_port_arbiter.sv
// Two-requester arbiter for the 16x32 register file ports: req 0 has priority,
// req 1 gets a starvation guard and a lock mode; responses come back one cycle after grant.
module regfile_port_arbiter #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_WAIT   = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                req_valid,
   output logic [1:0]                req_ready,
   input  logic                      req_lock,
   input  logic [1:0]                req_write_en,
   input  logic [2*ADDR_WIDTH-1:0]   req_write_addr,
   input  logic [2*DATA_WIDTH-1:0]   req_write_data,
   input  logic [2*ADDR_WIDTH-1:0]   req_read_addr_a,
   input  logic [2*ADDR_WIDTH-1:0]   req_read_addr_b,
   output logic [1:0]                resp_valid,
   output logic [DATA_WIDTH-1:0]     resp_data_a,
   output logic [DATA_WIDTH-1:0]     resp_data_b,
   output logic                      rf_write_en,
   output logic [ADDR_WIDTH-1:0]     rf_write_addr,
   output logic [DATA_WIDTH-1:0]     rf_write_data,
   output logic [ADDR_WIDTH-1:0]     rf_read_addr_a,
   output logic [ADDR_WIDTH-1:0]     rf_read_addr_b,
   input  logic [DATA_WIDTH-1:0]     rf_read_data_a,
   input  logic [DATA_WIDTH-1:0]     rf_read_data_b
);
   localparam int CW = $clog2(MAX_WAIT + 1);
   localparam logic [CW-1:0] WAIT_MAX = CW'(MAX_WAIT);

   typedef enum logic {ARB, LOCKED} state_e;

   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] wa;
      logic [DATA_WIDTH-1:0] wd;
      logic [ADDR_WIDTH-1:0] ra;
      logic [ADDR_WIDTH-1:0] rb;
   } req_t;

   req_t [1:0] req;

   for (genvar g = 0; g < 2; g++) begin : g_req
      assign req[g].we = req_write_en[g];
      assign req[g].wa = req_write_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign req[g].wd = req_write_data[g*DATA_WIDTH +: DATA_WIDTH];
      assign req[g].ra = req_read_addr_a[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign req[g].rb = req_read_addr_b[g*ADDR_WIDTH +: ADDR_WIDTH];
   end

   state_e                state_q, state_d;
   logic [CW-1:0]         wait_cnt_q, wait_cnt_d;
   logic [1:0]            resp_valid_q, resp_valid_d;
   logic                  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic                  zero_a_q, zero_a_d, zero_b_q, zero_b_d;
   logic [DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;
   logic [1:0]            gnt;
   req_t                  sel;

   always_comb begin
      gnt     = 2'b00;
      state_d = state_q;
      case (state_q)
         ARB: begin
            if (req_valid[1] && wait_cnt_q == WAIT_MAX) gnt = 2'b10;
            else if (req_valid[0])                      gnt = 2'b01;
            else if (req_valid[1])                      gnt = 2'b10;
            if (gnt[1] && req_lock) state_d = LOCKED;
         end
         LOCKED: begin
            if (req_valid[1]) gnt = 2'b10;
            if (gnt[1] && !req_lock) state_d = ARB;
         end
         default: state_d = ARB;
      endcase

      wait_cnt_d = wait_cnt_q;
      if (!req_valid[1] || gnt[1])  wait_cnt_d = '0;
      else if (wait_cnt_q != WAIT_MAX) wait_cnt_d = wait_cnt_q + CW'(1);

      // Ungranted cycles still present req 0 fields; only write_en is qualified.
      sel            = gnt[1] ? req[1] : req[0];
      rf_write_en    = sel.we & (|gnt);
      rf_write_addr  = sel.wa;
      rf_write_data  = sel.wd;
      rf_read_addr_a = sel.ra;
      rf_read_addr_b = sel.rb;
      req_ready      = gnt;

      // File returns pre-write data on a same-address hit, so the write data is replayed.
      resp_valid_d = gnt;
      fwd_a_d      = rf_write_en && (sel.wa != '0) && (sel.wa == sel.ra);
      fwd_b_d      = rf_write_en && (sel.wa != '0) && (sel.wa == sel.rb);
      zero_a_d     = (sel.ra == '0);
      zero_b_d     = (sel.rb == '0);
      fwd_data_d   = sel.wd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ARB;
         wait_cnt_q   <= '0;
         resp_valid_q <= 2'b00;
         fwd_a_q      <= 1'b0;
         fwd_b_q      <= 1'b0;
         zero_a_q     <= 1'b0;
         zero_b_q     <= 1'b0;
         fwd_data_q   <= '0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         resp_valid_q <= resp_valid_d;
         fwd_a_q      <= fwd_a_d;
         fwd_b_q      <= fwd_b_d;
         zero_a_q     <= zero_a_d;
         zero_b_q     <= zero_b_d;
         fwd_data_q   <= fwd_data_d;
      end
   end

   always_comb begin
      resp_valid  = resp_valid_q;
      resp_data_a = '0;
      resp_data_b = '0;
      if (|resp_valid_q) begin
         if (zero_a_q)     resp_data_a = '0;
         else if (fwd_a_q) resp_data_a = fwd_data_q;
         else              resp_data_a = rf_read_data_a;
         if (zero_b_q)     resp_data_b = '0;
         else if (fwd_b_q) resp_data_b = fwd_data_q;
         else              resp_data_b = rf_read_data_b;
      end
   end
endmodule

// File: tb/tb_regfile_port_arbiter.sv
// Directed bench for regfile_port_arbiter with a small behavioural register file
// (registered read of pre-write data, r0 hard-wired to zero).
module tb_regfile_port_arbiter;
   localparam int AW = 4;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    req_valid;
   logic [1:0]    req_ready;
   logic          req_lock;
   logic [1:0]    req_write_en;
   logic [2*AW-1:0] req_write_addr, req_read_addr_a, req_read_addr_b;
   logic [2*DW-1:0] req_write_data;
   logic [1:0]    resp_valid;
   logic [DW-1:0] resp_data_a, resp_data_b;
   logic          rf_write_en;
   logic [AW-1:0] rf_write_addr, rf_read_addr_a, rf_read_addr_b;
   logic [DW-1:0] rf_write_data, rf_read_data_a, rf_read_data_b;

   int tests  = 0;
   int errors = 0;

   logic [DW-1:0] mem [16];

   always #5 clk = ~clk;

   regfile_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_WAIT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_lock(req_lock),
      .req_write_en(req_write_en), .req_write_addr(req_write_addr),
      .req_write_data(req_write_data), .req_read_addr_a(req_read_addr_a),
      .req_read_addr_b(req_read_addr_b),
      .resp_valid(resp_valid), .resp_data_a(resp_data_a), .resp_data_b(resp_data_b),
      .rf_write_en(rf_write_en), .rf_write_addr(rf_write_addr), .rf_write_data(rf_write_data),
      .rf_read_addr_a(rf_read_addr_a), .rf_read_addr_b(rf_read_addr_b),
      .rf_read_data_a(rf_read_data_a), .rf_read_data_b(rf_read_data_b)
   );

   // Register file environment model
   always @(posedge clk) begin
      rf_read_data_a <= (rf_read_addr_a == 0) ? '0 : mem[rf_read_addr_a];
      rf_read_data_b <= (rf_read_addr_b == 0) ? '0 : mem[rf_read_addr_b];
      if (rf_write_en && rf_write_addr != 0) mem[rf_write_addr] <= rf_write_data;
   end

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      tests++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int r, input logic we, input logic [AW-1:0] wa,
                          input logic [DW-1:0] wd, input logic [AW-1:0] ra,
                          input logic [AW-1:0] rb);
      req_valid[r]                 = 1'b1;
      req_write_en[r]              = we;
      req_write_addr[r*AW +: AW]   = wa;
      req_write_data[r*DW +: DW]   = wd;
      req_read_addr_a[r*AW +: AW]  = ra;
      req_read_addr_b[r*AW +: AW]  = rb;
   endtask

   task automatic idle();
      req_valid    = 2'b00;
      req_write_en = 2'b00;
      req_lock     = 1'b0;
   endtask

   // advance to just after the next rising edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem[3] = 32'h11;
      mem[5] = 32'h22;
      req_write_addr = '0; req_write_data = '0;
      req_read_addr_a = '0; req_read_addr_b = '0;
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_resp_valid", 32'(resp_valid), 32'h0);
      chk("reset_resp_data_a", resp_data_a, 32'h0);
      chk("reset_ready_idle", 32'(req_ready), 32'h0);
      rst_n = 1'b1;
      step();

      // basic read by req 0
      set_req(0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd5);
      @(negedge clk);
      chk("rd_ready", 32'(req_ready), 32'h1);
      chk("rd_addr_a", 32'(rf_read_addr_a), 32'h3);
      chk("rd_addr_b", 32'(rf_read_addr_b), 32'h5);
      chk("rd_wen", 32'(rf_write_en), 32'h0);
      step();
      idle();
      @(negedge clk);
      chk("rd_resp_valid", 32'(resp_valid), 32'h1);
      chk("rd_data_a", resp_data_a, 32'h11);
      chk("rd_data_b", resp_data_b, 32'h22);
      step();

      // write r7 + read a=7, b=0 in one grant; then back-to-back read of r7
      set_req(0, 1'b1, 4'd7, 32'hDEAD, 4'd7, 4'd0);
      @(negedge clk);
      chk("fwd_wen", 32'(rf_write_en), 32'h1);
      chk("fwd_waddr", 32'(rf_write_addr), 32'h7);
      step();
      idle();
      set_req(0, 1'b0, 4'd0, 32'h0, 4'd7, 4'd5);
      @(negedge clk);
      chk("fwd_data_a", resp_data_a, 32'hDEAD);
      chk("fwd_data_b_r0", resp_data_b, 32'h0);
      step();
      idle();
      @(negedge clk);
      chk("b2b_data_a", resp_data_a, 32'hDEAD);
      chk("b2b_data_b", resp_data_b, 32'h22);
      step();

      // independent B-port forwarding
      set_req(0, 1'b1, 4'd9, 32'h1234, 4'd3, 4'd9);
      step();
      idle();
      @(negedge clk);
      chk("fwdb_data_a", resp_data_a, 32'h11);
      chk("fwdb_data_b", resp_data_b, 32'h1234);
      step();

      // starvation guard: req0 x4, req1 on the 5th, then req0 again
      for (int i = 0; i < 6; i++) begin
         set_req(0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
         set_req(1, 1'b0, 4'd0, 32'h0, 4'd5, 4'd5);
         @(negedge clk);
         chk($sformatf("starve_ready_%0d", i), 32'(req_ready), (i == 4) ? 32'h2 : 32'h1);
         if (i == 5) begin
            chk("starve_resp_valid", 32'(resp_valid), 32'h2);
            chk("starve_resp_data", resp_data_a, 32'h22);
         end
         step();
      end
      idle();
      step();

      // lock mode
      set_req(1, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
      req_lock = 1'b1;
      @(negedge clk);
      chk("lock_grant", 32'(req_ready), 32'h2);
      step();
      idle();
      for (int i = 0; i < 3; i++) begin
         set_req(0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
         @(negedge clk);
         chk($sformatf("locked_ready_%0d", i), 32'(req_ready), 32'h0);
         step();
      end
      set_req(1, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
      req_lock = 1'b0;
      @(negedge clk);
      chk("unlock_grant", 32'(req_ready), 32'h2);
      step();
      idle();
      set_req(0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
      @(negedge clk);
      chk("after_unlock", 32'(req_ready), 32'h1);
      step();
      idle();
      step();

      // write to r0 passes through, read of r0 is zero
      set_req(0, 1'b1, 4'd0, 32'h5, 4'd0, 4'd3);
      @(negedge clk);
      chk("r0_wen", 32'(rf_write_en), 32'h1);
      chk("r0_waddr", 32'(rf_write_addr), 32'h0);
      step();
      idle();
      @(negedge clk);
      chk("r0_data_a", resp_data_a, 32'h0);
      step();

      // reset with a grant in flight and wait_cnt saturated
      for (int i = 0; i < 4; i++) begin
         set_req(0, 1'b0, 4'd0, 32'h0, 4'd3, 4'd3);
         set_req(1, 1'b0, 4'd0, 32'h0, 4'd5, 4'd5);
         step();
      end
      #1 rst_n = 1'b0;
      #1;
      chk("rst_resp_valid", 32'(resp_valid), 32'h0);
      chk("rst_resp_data", resp_data_a, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_wait_cleared", 32'(req_ready), 32'h1);
      step();
      idle();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
